// File: rtl/keypad_scanner_pkg.sv
// Shared types, codes and key map for the 4x3 keypad scanner.
// Optional key_strobe output enabled by KEYPAD_STROBE_EN.
package keypad_pkg;

   localparam logic [3:0] NOKEY = 4'd10;

   typedef enum logic [1:0] {
      SCAN        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   // Indexed by row*3+col; '*' and '#' decode to NOKEY.
   localparam logic [3:0] KEY_MAP [0:11] = '{
      4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6,
      4'd7, 4'd8, 4'd9,
      NOKEY, 4'd0, NOKEY
   };

   function automatic logic [3:0] key_code(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] idx;
      idx = {2'b00, r} * 4'd3 + {2'b00, c};
      return KEY_MAP[idx];
   endfunction

   function automatic logic one_low(input logic [3:0] r);
      return $countones(~r) == 1;
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd3;
      unique case (1'b1)
         !r[0]:   idx = 2'd0;
         !r[1]:   idx = 2'd1;
         !r[2]:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [2:0] c);
      logic [1:0] idx;
      idx = 2'd2;
      unique case (1'b1)
         !c[0]:   idx = 2'd0;
         !c[1]:   idx = 2'd1;
         default: idx = 2'd2;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and decoded-key bundle between scanner and its neighbours.
// key_strobe is present only when KEYPAD_STROBE_EN is defined.
interface keypad_scanner_if;

   logic [3:0] row;
   logic [2:0] col;
   logic [3:0] key;
`ifdef KEYPAD_STROBE_EN
   logic       key_strobe;

   modport master (input row, output col, output key, output key_strobe);
   modport slave  (output row, input col, input key, input key_strobe);
`else
   modport master (input row, output col, output key);
   modport slave  (output row, input col, input key);
`endif

endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-high so an idle keypad is seen immediately.
module keypad_row_sync (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] row_s
);

   logic [3:0] meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta  <= 4'hF;
         row_s <= 4'hF;
      end else begin
         meta  <= row;
         row_s <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce.
// Define KEYPAD_STROBE_EN to add a one-clock key_strobe on each new digit.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              scan_tick,
   keypad_scanner_if.master  bus
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_TICKS);

   logic [3:0] row_s;
   state_t     state;
   logic [3:0] count;
   logic [1:0] lat_row;
   logic [1:0] lat_col;
   logic [2:0] col;
   logic [3:0] key;
   logic [3:0] count_next;
   logic [3:0] pattern;
   logic [3:0] code;
`ifdef KEYPAD_STROBE_EN
   logic       strobe;
`endif

   keypad_row_sync u_sync (
      .clock (clock),
      .reset (reset),
      .row   (bus.row),
      .row_s (row_s)
   );

   assign count_next = count + 4'd1;
   assign pattern    = ~(4'b0001 << lat_row);
   assign code       = key_code(lat_row, lat_col);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= SCAN;
         count   <= 4'd0;
         lat_row <= 2'd0;
         lat_col <= 2'd0;
         col     <= 3'b110;
         key     <= NOKEY;
`ifdef KEYPAD_STROBE_EN
         strobe  <= 1'b0;
`endif
      end else begin
`ifdef KEYPAD_STROBE_EN
         strobe <= 1'b0;
`endif
         if (scan_tick) begin
            unique case (state)
               SCAN: begin
                  if (row_s != 4'hF && one_low(row_s)) begin
                     lat_row <= row_index(row_s);
                     lat_col <= col_index(col);
                     count   <= 4'd1;
                     state   <= DEB_PRESS;
                  end else begin
                     col <= {col[1:0], col[2]};
                  end
               end
               DEB_PRESS: begin
                  if (row_s == pattern) begin
                     count <= count_next;
                     if (count_next == DEB) begin
                        state <= HELD;
                        key   <= code;
`ifdef KEYPAD_STROBE_EN
                        strobe <= (code != NOKEY);
`endif
                     end
                  end else begin
                     // col stays put; rotation resumes next tick
                     count <= 4'd0;
                     state <= SCAN;
                  end
               end
               HELD: begin
                  if (row_s == 4'hF) begin
                     count <= 4'd1;
                     state <= DEB_RELEASE;
                  end
               end
               DEB_RELEASE: begin
                  if (row_s == 4'hF) begin
                     count <= count_next;
                     if (count_next == DEB) begin
                        count <= 4'd0;
                        key   <= NOKEY;
                        state <= SCAN;
                     end
                  end else begin
                     count <= 4'd0;
                     state <= HELD;
                  end
               end
            endcase
         end
      end
   end

   assign bus.col = col;
   assign bus.key = key;
`ifdef KEYPAD_STROBE_EN
   assign bus.key_strobe = strobe;
`endif

endmodule
